// File: rtl/stream_window_3.sv
// stream_window_3: raster-order pixel stream to 3x3 sliding window.
// Two line buffers hold the previous two rows. A 3x3 register window shifts
// left once per accepted pixel. Outputs are registered (latency 1).
// Optional feature macro: STREAM_WINDOW_BORDER_MASK_EN. When it is defined,
// every accepted pixel produces a window, and taps outside the frame read as 0.
// Handshake: in_valid qualifies pixel_in/sof on the rising edge. There is no
// backpressure. window_valid is high for exactly one cycle per produced window.
module stream_window_3 #(
    parameter int PRECISION = 16,
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    input  logic                                    sof,
    input  logic signed [PRECISION-1:0]             pixel_in,
    output logic signed [2:0][2:0][PRECISION-1:0]   buffer_3,
    output logic                                    window_valid,
    output logic        [$clog2(HEIGHT)-1:0]        center_row,
    output logic        [$clog2(WIDTH)-1:0]         center_col
);

    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] col, cur_col, pos_col;
    logic [RW-1:0] row, cur_row, pos_row;

    logic [PRECISION-1:0] lb1 [WIDTH];
    logic [PRECISION-1:0] lb2 [WIDTH];
    logic [PRECISION-1:0] lb1_rd, lb2_rd;

    logic [2:0][2:0][PRECISION-1:0] win;

    // Position of the incoming pixel; sof forces it to (0,0).
    always_comb begin
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
        lb1_rd  = lb1[cur_col];
        lb2_rd  = lb2[cur_col];
    end

    // Raster position counters, advancing once per accepted pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (cur_col == CW'(WIDTH - 1)) begin
                col <= '0;
                row <= (cur_row == RW'(HEIGHT - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    // Line buffers: read old data, then push the column down one row.
    // Contents are not cleared because stale entries are never exposed unmasked.
    always_ff @(posedge clk) begin
        if (!reset && in_valid) begin
            lb1[cur_col] <= pixel_in;
            lb2[cur_col] <= lb1_rd;
        end
    end

    // Window shift, window flag, and position of the newest pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            win          <= '0;
            pos_row      <= '0;
            pos_col      <= '0;
            window_valid <= 1'b0;
        end else begin
            window_valid <= 1'b0;
            if (in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb2_rd;
                win[1][2] <= lb1_rd;
                win[2][2] <= pixel_in;
                pos_row   <= cur_row;
                pos_col   <= cur_col;
`ifdef STREAM_WINDOW_BORDER_MASK_EN
                window_valid <= 1'b1;
`else
                window_valid <= (cur_row >= RW'(2)) && (cur_col >= CW'(2));
`endif
            end
        end
    end

    // The centre is one row and one column behind the newest pixel, clamped at 0.
    always_comb begin
        center_row = (pos_row == '0) ? '0 : pos_row - RW'(1);
        center_col = (pos_col == '0) ? '0 : pos_col - CW'(1);
    end

`ifdef STREAM_WINDOW_BORDER_MASK_EN
    // Zero-pad taps that fall above or left of the current frame.
    always_comb begin
        buffer_3 = win;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if ((int'(pos_row) < 2 - r) || (int'(pos_col) < 2 - c))
                    buffer_3[r][c] = '0;
            end
        end
    end
`else
    // Taps pass through unmodified.
    always_comb begin
        buffer_3 = win;
    end
`endif

endmodule

// File: tb/tb_stream_window_3.sv
// Bench for stream_window_3 (WIDTH=4, HEIGHT=4, PRECISION=16).
// The reference model is a frame image indexed by (row, col). The expected
// window is read straight from that image around the pixel's raster position.
module tb_stream_window_3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int P  = 16;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
`ifdef STREAM_WINDOW_BORDER_MASK_EN
  localparam int WIN_PER_FRAME = 16;
  localparam int FIRST_OFS     = 0;
`else
  localparam int WIN_PER_FRAME = 4;
  localparam int FIRST_OFS     = 10;
`endif

  logic clk = 1'b0;
  logic reset, in_valid, sof;
  logic signed [P-1:0] pixel_in;
  logic signed [2:0][2:0][P-1:0] buffer_3;
  logic window_valid;
  logic [RW-1:0] center_row;
  logic [CW-1:0] center_col;

  stream_window_3 #(.PRECISION(P), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sof(sof), .pixel_in(pixel_in),
    .buffer_3(buffer_3), .window_valid(window_valid),
    .center_row(center_row), .center_col(center_col)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [P-1:0] img [H][W];
  int mr, mc;
  logic exp_valid;
  logic [2:0][2:0][P-1:0] exp_buf;
  int exp_cr, exp_cc;
  logic [P-1:0] last_px;

  // Drive one cycle of input, then advance the model to match.
  task automatic step(input logic v, input logic s, input logic [P-1:0] px);
    int rr, cc, n;
    in_valid = v; sof = s; pixel_in = px;
    @(posedge clk); #1;
    if (v) begin
      if (s) begin mr = 0; mc = 0; end
      img[mr][mc] = px;
      last_px = px;
`ifdef STREAM_WINDOW_BORDER_MASK_EN
      exp_valid = 1'b1;
`else
      exp_valid = (mr >= 2) && (mc >= 2);
`endif
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          rr = mr - 2 + r; cc = mc - 2 + c;
          exp_buf[r][c] = (rr < 0 || cc < 0) ? '0 : img[rr][cc];
        end
      exp_cr = (mr > 0) ? mr - 1 : 0;
      exp_cc = (mc > 0) ? mc - 1 : 0;
      n = (mr * W + mc + 1) % (W * H);
      mr = n / W; mc = n % W;
    end else begin
      exp_valid = 1'b0;
    end
    in_valid = 1'b0; sof = 1'b0;
  endtask

  // Hold reset for two edges while presenting a pixel, which must be dropped.
  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b1; sof = 1'b1; pixel_in = P'($urandom);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; sof = 1'b0;
    mr = 0; mc = 0; exp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (window_valid !== 1'b0 || buffer_3 !== '0 || center_row !== '0 || center_col !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b buf=%h crow=%0d ccol=%0d, required all zero",
               window_valid, buffer_3, center_row, center_col);
    end
  endtask

  // Pixel value 4*row+col, one frame with sof on the first pixel.
  task automatic test_frame();
    int nvalid = 0;
    logic seen = 1'b0;
    logic [2:0][2:0][P-1:0] k;
    k = {16'd10, 16'd9, 16'd8, 16'd6, 16'd5, 16'd4, 16'd2, 16'd1, 16'd0};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, P'(i));
      checks++;
      if (window_valid !== exp_valid) begin
        failures++;
        $display("FAIL frame_valid px=%0d: got %b required %b", i, window_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (buffer_3 !== exp_buf || center_row !== RW'(exp_cr) || center_col !== CW'(exp_cc)) begin
          failures++;
          $display("FAIL frame_window px=%0d: got %h (%0d,%0d) required %h (%0d,%0d)",
                   i, buffer_3, center_row, center_col, exp_buf, exp_cr, exp_cc);
        end
      end
      if (window_valid === 1'b1) nvalid++;
`ifndef STREAM_WINDOW_BORDER_MASK_EN
      if (window_valid === 1'b1 && !seen) begin
        seen = 1'b1;
        checks++;
        if (i != 10 || buffer_3 !== k || center_row !== RW'(1) || center_col !== CW'(1)) begin
          failures++;
          $display("FAIL first_window: px=%0d got %h (%0d,%0d) required px=10 %h (1,1)",
                   i, buffer_3, center_row, center_col, k);
        end
      end
`endif
    end
    checks++;
    if (nvalid != WIN_PER_FRAME) begin
      failures++;
      $display("FAIL frame_count: got %0d required %0d", nvalid, WIN_PER_FRAME);
    end
  endtask

  // Same frame with a stall between every pair of pixels.
  task automatic test_stall();
    int nvalid = 0;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(i[0] == 1'b0, i == 0, P'($urandom));
      checks++;
      if (window_valid !== exp_valid) begin
        failures++;
        $display("FAIL stall_valid cyc=%0d: got %b required %b", i, window_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (buffer_3 !== exp_buf || center_row !== RW'(exp_cr) || center_col !== CW'(exp_cc)) begin
          failures++;
          $display("FAIL stall_window cyc=%0d: got %h required %h", i, buffer_3, exp_buf);
        end
      end
      if (window_valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != WIN_PER_FRAME) begin
      failures++;
      $display("FAIL stall_count: got %0d required %0d", nvalid, WIN_PER_FRAME);
    end
  endtask

  // Two frames back to back; the second relies on the natural row wrap.
  task automatic test_back_to_back();
    int nvalid = 0;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, i == 0, P'($urandom));
      checks++;
      if (window_valid !== exp_valid) begin
        failures++;
        $display("FAIL b2b_valid px=%0d: got %b required %b", i, window_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (buffer_3 !== exp_buf || center_row !== RW'(exp_cr) || center_col !== CW'(exp_cc)) begin
          failures++;
          $display("FAIL b2b_window px=%0d: got %h (%0d,%0d) required %h (%0d,%0d)",
                   i, buffer_3, center_row, center_col, exp_buf, exp_cr, exp_cc);
        end
      end
      if (window_valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 2 * WIN_PER_FRAME) begin
      failures++;
      $display("FAIL b2b_count: got %0d required %0d", nvalid, 2 * WIN_PER_FRAME);
    end
  endtask

  // Reset after pixel 9, then restream without sof.
  task automatic test_reset_mid();
    int nvalid = 0;
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, P'($urandom));
    do_reset();
    checks++;
    if (window_valid !== 1'b0 || buffer_3 !== '0 || center_row !== '0 || center_col !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: valid=%b buf=%h, required zero", window_valid, buffer_3);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, P'($urandom));
      checks++;
      if (window_valid !== exp_valid) begin
        failures++;
        $display("FAIL midreset_valid px=%0d: got %b required %b", i, window_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (buffer_3 !== exp_buf) begin
          failures++;
          $display("FAIL midreset_window px=%0d: got %h required %h", i, buffer_3, exp_buf);
        end
      end
      if (window_valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != WIN_PER_FRAME) begin
      failures++;
      $display("FAIL midreset_count: got %0d required %0d", nvalid, WIN_PER_FRAME);
    end
  endtask

  // sof on pixel 6 of a frame restarts the raster position.
  task automatic test_sof_resync();
    int first = -1;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      step(1'b1, (i == 0) || (i == 6), P'($urandom));
      checks++;
      if (window_valid !== exp_valid) begin
        failures++;
        $display("FAIL resync_valid px=%0d: got %b required %b", i, window_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (buffer_3 !== exp_buf || center_row !== RW'(exp_cr) || center_col !== CW'(exp_cc)) begin
          failures++;
          $display("FAIL resync_window px=%0d: got %h required %h", i, buffer_3, exp_buf);
        end
      end
      if (i >= 6 && window_valid === 1'b1 && first < 0) first = i - 6;
    end
    checks++;
    if (first != FIRST_OFS) begin
      failures++;
      $display("FAIL resync_first: got offset %0d required %0d", first, FIRST_OFS);
    end
  endtask

  // Random valid gaps and occasional sof.
  task automatic test_random();
    logic v, s;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 40) == 0);
      step(v, s, P'($urandom));
      checks++;
      if (window_valid !== exp_valid) begin
        failures++;
        $display("FAIL rand_valid cyc=%0d: got %b required %b", i, window_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (buffer_3 !== exp_buf || center_row !== RW'(exp_cr) || center_col !== CW'(exp_cc)) begin
          failures++;
          $display("FAIL rand_window cyc=%0d: got %h (%0d,%0d) required %h (%0d,%0d)",
                   i, buffer_3, center_row, center_col, exp_buf, exp_cr, exp_cc);
        end
      end
      if (v) begin
        checks++;
        if (buffer_3[2][2] !== last_px) begin
          failures++;
          $display("FAIL rand_newest cyc=%0d: got %h required %h", i, buffer_3[2][2], last_px);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; sof = 1'b0; pixel_in = '0;
    test_reset();
    test_frame();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_sof_resync();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
